// File: rtl/key_debounce.sv
// Debounces N_KEYS raw buttons against a prescaled sample tick and emits a clean level
// plus one-cycle press/release pulses. Define KEY_REPEAT_EN to add auto-repeat on held keys.
module key_debounce #(
    parameter int unsigned N_KEYS        = 8,
    parameter int unsigned SAMPLE_DIV    = 499999,
    parameter int unsigned STABLE_CNT    = 3,
    parameter int unsigned REPEAT_DELAY  = 50,
    parameter int unsigned REPEAT_PERIOD = 10
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              sample_tick
);

    localparam int unsigned DIV_W  = (SAMPLE_DIV < 1) ? 1 : $clog2(SAMPLE_DIV + 1);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_e;

    if (N_KEYS < 1 || N_KEYS > 16 || STABLE_CNT < 2 || STABLE_CNT > 15 ||
        REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_bad_param
        $error("key_debounce: parameter out of range");
    end

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick_q;

    key_state_e        state_q [N_KEYS];
    key_state_e        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] level_d;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] accept_press_c;
    logic [N_KEYS-1:0] repeat_press_c;

    // Two-flop synchronizer per key
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_in;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler: tick is registered, high the cycle after the counter hits SAMPLE_DIV
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_q == DIV_W'(SAMPLE_DIV)) begin
            div_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    // Per-key debounce FSM state and registered outputs
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state logic; only sample ticks advance the FSMs
    always_comb begin
        for (int i = 0; i < int'(N_KEYS); i++) begin
            state_d[i]        = state_q[i];
            cnt_d[i]          = cnt_q[i];
            level_d[i]        = level_q[i];
            accept_press_c[i] = 1'b0;
            release_d[i]      = 1'b0;
            if (tick_q) begin
                unique case (state_q[i])
                    RELEASED: begin
                        if (sync2_q[i]) begin
                            state_d[i] = PRESS_CHK;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (!sync2_q[i]) begin
                            state_d[i] = RELEASED;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            if ((cnt_q[i] + CNT_W'(1)) == CNT_W'(STABLE_CNT)) begin
                                state_d[i]        = PRESSED;
                                level_d[i]        = 1'b1;
                                accept_press_c[i] = 1'b1;
                            end
                        end
                    end
                    PRESSED: begin
                        if (!sync2_q[i]) begin
                            state_d[i] = RELEASE_CHK;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    RELEASE_CHK: begin
                        if (sync2_q[i]) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            if ((cnt_q[i] + CNT_W'(1)) == CNT_W'(STABLE_CNT)) begin
                                state_d[i]   = RELEASED;
                                level_d[i]   = 1'b0;
                                release_d[i] = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

`ifdef KEY_REPEAT_EN
    logic [HOLD_W-1:0] hold_q [N_KEYS];
    logic [HOLD_W-1:0] hold_d [N_KEYS];
    logic [HOLD_W-1:0] hold_inc_c;
    logic [N_KEYS-1:0] rep_q;
    logic [N_KEYS-1:0] rep_d;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                hold_q[i] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                hold_q[i] <= hold_d[i];
            end
            rep_q <= rep_d;
        end
    end

    // Hold counter: initial delay phase, then a shorter periodic phase (rep_q set)
    always_comb begin
        hold_inc_c = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            hold_d[i]         = hold_q[i];
            rep_d[i]          = rep_q[i];
            repeat_press_c[i] = 1'b0;
            hold_inc_c        = hold_q[i] + HOLD_W'(1);
            if (state_d[i] == RELEASED ||
                (state_q[i] == PRESS_CHK && state_d[i] == PRESSED)) begin
                hold_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (tick_q && state_q[i] == PRESSED && state_d[i] == PRESSED) begin
                if (!rep_q[i] && hold_inc_c == HOLD_W'(REPEAT_DELAY)) begin
                    hold_d[i]         = '0;
                    rep_d[i]          = 1'b1;
                    repeat_press_c[i] = 1'b1;
                end else if (rep_q[i] && hold_inc_c == HOLD_W'(REPEAT_PERIOD)) begin
                    hold_d[i]         = '0;
                    repeat_press_c[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_inc_c;
                end
            end
        end
    end
`else
    assign repeat_press_c = '0;
`endif

    assign press_d     = accept_press_c | repeat_press_c;

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign sample_tick = tick_q;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Sampling-side consumer of a slow time base: an internal prescaler makes a one-cycle sample tick, and the block debounces N_KEYS raw button inputs (floor calls, door open/close) against that tick.
- Each key gets a clean level plus one-cycle press and release pulses, all in the clkin domain.
- Sits between board buttons and the elevator request/controller logic. The sample tick is also exported for other slow-rate consumers.

Parameters:
N_KEYS, 8, number of independent key inputs (1..16)
SAMPLE_DIV, 499999, prescaler terminal count; tick every SAMPLE_DIV+1 clkin cycles (10 ms at 50 MHz)
STABLE_CNT, 3, consecutive equal samples required to accept a level change (2..15)
REPEAT_DELAY, 50, samples held before first auto-repeat (only with KEY_REPEAT_EN; 1..255)
REPEAT_PERIOD, 10, samples between auto-repeats (only with KEY_REPEAT_EN; 1..255)

Ports:
clkin  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
keys_in  in  N_KEYS  raw asynchronous buttons, 1 = pressed
key_level  out  N_KEYS  debounced level per key
key_press  out  N_KEYS  one-cycle pulse on accepted press (also on auto-repeat when enabled)
key_release  out  N_KEYS  one-cycle pulse on accepted release
sample_tick  out  1  one-cycle pulse each prescaler wrap

Behaviour:
Reset:
- rst is asynchronous and active-high. Asserting it clears all outputs, synchronizers, the prescaler, FSMs and counters immediately.
- After reset: key_level=0, key_press=0, key_release=0, sample_tick=0, all FSMs in RELEASED.
- Reset mid-debounce or mid-hold discards all progress. No pulse is emitted on reset entry or exit.

Synchronizer:
- Two flops per key, reset 0. The synchronized value s[i] lags keys_in by 2 cycles.

Prescaler:
- Counter runs 0..SAMPLE_DIV. At SAMPLE_DIV it wraps to 0.
- sample_tick is registered high for exactly the cycle after the counter equals SAMPLE_DIV.
- The counter width is the minimum needed to hold SAMPLE_DIV.

Per-key FSM (advances only in cycles where sample_tick=1; cnt is 4 bits):
- RELEASED: s=1 -> PRESS_CHK, cnt=1. s=0 -> stay.
- PRESS_CHK: s=0 -> RELEASED, cnt=0. s=1 -> cnt+1; if cnt+1==STABLE_CNT -> PRESSED, key_level<=1, key_press pulse.
- PRESSED: s=0 -> RELEASE_CHK, cnt=1. s=1 -> stay.
- RELEASE_CHK: s=1 -> PRESSED, cnt=0. s=0 -> cnt+1; if cnt+1==STABLE_CNT -> RELEASED, key_level<=0, key_release pulse.

Output timing:
- key_level changes, and key_press/key_release assert, in the cycle after the accepting tick.
- Each pulse is high for exactly 1 cycle.
- Keys are fully independent; simultaneous accepts on several keys give simultaneous pulses.
- A glitch shorter than STABLE_CNT samples never changes key_level.
- key_press and key_release are never high together for the same key.

Optional Feature:
KEY_REPEAT_EN
- Defined: an 8-bit hold counter per key clears on entry to PRESSED and increments on each tick while in PRESSED.
  - When it reaches REPEAT_DELAY, an extra key_press pulse is emitted.
  - After that, a pulse is emitted every REPEAT_PERIOD ticks while the key stays in PRESSED.
  - Entering RELEASE_CHK freezes the counter. Returning to PRESSED resumes it; reaching RELEASED clears it.
- Undefined: no hold counter is built, and key_press fires exactly once per accepted press.

Test Plan:
- Sim params SAMPLE_DIV=9, STABLE_CNT=3: assert rst mid-run -> all outputs 0 within the same cycle, no pulses after release. sample_tick then fires on cycle 10 after reset release and every 10 cycles after.
- keys_in[0] goes 1 and stays -> key_press[0] high for 1 cycle after the 3rd tick sampling 1; key_level[0]=1 from that cycle.
- keys_in[0] bounces 1,0 within 2 ticks -> key_level[0] stays 0, no key_press.
- Release after stable press -> key_release[0] 1-cycle pulse after the 3rd tick sampling 0; key_level[0]=0.
- keys_in[2] and keys_in[5] rise in the same cycle -> key_press[2] and key_press[5] pulse in the same cycle.
- KEY_REPEAT_EN with REPEAT_DELAY=4, REPEAT_PERIOD=2, key held -> press pulses at accept, then 4 ticks later, then every 2 ticks. Without the macro -> a single pulse only.
